// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage to external 16-bit SRAM bridge.
// State encoding, default geometry and strobe polarity live here.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_BASE   = 1024;
  localparam int DEF_SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W     = 16;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit asynchronous SRAM transactions,
// holding ready low while the access is in flight.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [CNT_W-1:0]         cnt_r;
  logic                     last_s;
  logic                     op_wr_r;
  logic                     op_wr_nxt_s;
  logic                     in_xfer_nxt_s;
  logic                     we_n_nxt_s;
  logic                     oe_n_nxt_s;
  logic                     dq_oe_nxt_s;
  logic                     we_n_r;
  logic                     oe_n_r;
  logic                     dq_oe_r;
  logic [SRAM_DATA_W-1:0]   lo_hold_r;
  logic [31:0]              read_data_r;
  logic [31:0]              offs_s;
  logic [SRAM_ADDR_W-2:0]   idx_s;
  logic                     hi_sel_s;
  logic [SRAM_DATA_W-1:0]   dq_out_s;
  logic                     unused_ok_s;

  // Out-of-range addresses simply wrap into the SRAM index space.
  assign offs_s      = address - 32'(ADDR_BASE);
  assign idx_s       = offs_s[SRAM_ADDR_W:2];
  assign unused_ok_s = ^{offs_s[1:0], offs_s[31:SRAM_ADDR_W+1]};
  assign hi_sel_s    = (state_r == HIGH);
  assign dq_out_s    = hi_sel_s ? write_data[31:16] : write_data[15:0];

  assign SRAM_ADDR = {idx_s, hi_sel_s};
  assign SRAM_DQ   = dq_oe_r ? dq_out_s : {SRAM_DATA_W{1'bz}};
  assign SRAM_WE_N = we_n_r;
  assign SRAM_OE_N = oe_n_r;
  assign SRAM_CE_N = STROBE_ON;
  assign SRAM_UB_N = STROBE_ON;
  assign SRAM_LB_N = STROBE_ON;
  assign read_data = read_data_r;
  assign ready     = ~(wr_en | rd_en) | (state_r == DONE);

  // Next-state, latched operation type and next-cycle strobe levels.
  always_comb begin
    state_nxt_s = state_r;
    op_wr_nxt_s = op_wr_r;
    last_s      = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        if (wr_en | rd_en) begin
          state_nxt_s = LOW;
          op_wr_nxt_s = wr_en;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          state_nxt_s = HIGH;
        end else begin
          state_nxt_s = LOW;
        end
      end
      HIGH: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = HIGH;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    // Strobes are registered from the next state so they line up with it.
    in_xfer_nxt_s = (state_nxt_s == LOW) || (state_nxt_s == HIGH);
    we_n_nxt_s    = (in_xfer_nxt_s && op_wr_nxt_s) ? STROBE_ON : STROBE_OFF;
    oe_n_nxt_s    = (in_xfer_nxt_s && !op_wr_nxt_s) ? STROBE_ON : STROBE_OFF;
    dq_oe_nxt_s   = in_xfer_nxt_s && op_wr_nxt_s;
  end

  // State register and per-state wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      op_wr_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      op_wr_r <= op_wr_nxt_s;
      if (state_nxt_s != state_r) begin
        cnt_r <= '0;
      end else if ((state_r == LOW) || (state_r == HIGH)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Registered SRAM strobes and data-bus drive enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_n_r  <= STROBE_OFF;
      oe_n_r  <= STROBE_OFF;
      dq_oe_r <= 1'b0;
    end else begin
      we_n_r  <= we_n_nxt_s;
      oe_n_r  <= oe_n_nxt_s;
      dq_oe_r <= dq_oe_nxt_s;
    end
  end

  // Low half is staged so read_data only changes once the whole word is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_hold_r   <= '0;
      read_data_r <= '0;
    end else if (!op_wr_r && last_s && (state_r == LOW)) begin
      lo_hold_r <= SRAM_DQ;
    end else if (!op_wr_r && last_s && (state_r == HIGH)) begin
      read_data_r <= {SRAM_DQ, lo_hold_r};
    end else begin
      lo_hold_r   <= lo_hold_r;
      read_data_r <= read_data_r;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table, corner sequences and randomized
// traffic checked against a word-level memory model; includes a WAIT_CYCLES=1 build.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int WAIT = 2;
  localparam int LAT  = 2 * WAIT + 1;
  localparam int LAT1 = 2 * 1 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;
  logic [15:0] mem [0:262143];

  logic        c_wr_en, c_rd_en;
  logic [31:0] c_address, c_write_data, c_read_data;
  logic        c_ready;
  wire  [15:0] c_sram_dq;
  logic [17:0] c_sram_addr;
  logic        c_we_n, c_oe_n, c_ce_n, c_ub_n, c_lb_n;
  logic [15:0] c_mem [0:262143];

  sram_controller #(.WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(c_wr_en), .rd_en(c_rd_en), .address(c_address),
    .write_data(c_write_data), .read_data(c_read_data), .ready(c_ready),
    .SRAM_DQ(c_sram_dq), .SRAM_ADDR(c_sram_addr), .SRAM_WE_N(c_we_n), .SRAM_OE_N(c_oe_n),
    .SRAM_CE_N(c_ce_n), .SRAM_UB_N(c_ub_n), .SRAM_LB_N(c_lb_n)
  );

  // Behavioural asynchronous SRAMs: drive DQ on OE_N low, store while WE_N low.
  assign sram_dq   = (oe_n == 1'b0) ? mem[sram_addr] : 16'bz;
  assign c_sram_dq = (c_oe_n == 1'b0) ? c_mem[c_sram_addr] : 16'bz;
  always @(posedge clk) if (we_n == 1'b0) mem[sram_addr] <= sram_dq;
  always @(posedge clk) if (c_we_n == 1'b0) c_mem[c_sram_addr] <= c_sram_dq;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          lo_idx;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;
  vec_t vecs [5];

  function automatic int widx(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) & 32'h0001_FFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    wr_en = w; rd_en = r; address = a; write_data = d;
    lat = 0;
    @(negedge clk);
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ready) begin
      total++; bad++;
      $display("FAIL timeout: ready still low after %0d cycles, want %0d", lat, LAT);
    end
    if (w) ref_mem[widx(a)] = d;
    else if (r) ref_rd = ref_mem[widx(a)];
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic access1(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat);
    c_wr_en = w; c_rd_en = ~w; c_address = a; c_write_data = d;
    lat = 0;
    @(negedge clk);
    while (!c_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!c_ready) begin
      total++; bad++;
      $display("FAIL timeout1: ready still low after %0d cycles, want %0d", lat, LAT1);
    end
    @(posedge clk); #1;
    c_wr_en = 1'b0; c_rd_en = 1'b0;
  endtask

  initial begin
    int lat;
    int sum;
    int idx;
    logic [31:0] a, d;
    logic w, r;

    vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 32'h0000_0000, 0, 16'hBEEF, 16'hDEAD};
    vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0000_0000, 32'hDEAD_BEEF, 0, 16'hBEEF, 16'hDEAD};
    vecs[2] = '{1'b1, 1'b0, 32'd1032, 32'h1234_5678, 32'hDEAD_BEEF, 4, 16'h5678, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 32'd1028, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 2, 16'h0F0F, 16'hA5A5};
    vecs[4] = '{1'b0, 1'b1, 32'd1032, 32'h0000_0000, 32'h1234_5678, 4, 16'h5678, 16'h1234};

    wr_en = 1'b0; rd_en = 1'b0; address = 32'd1024; write_data = 32'd0;
    c_wr_en = 1'b0; c_rd_en = 1'b0; c_address = 32'd1024; c_write_data = 32'd0;
    ref_rd = 32'd0;
    rst = 1'b1;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_read_data", read_data, 32'd0);
    check("reset_we_n", {31'd0, we_n}, 32'd1);
    check("reset_oe_n", {31'd0, oe_n}, 32'd1);
    check("reset_ce_n", {31'd0, ce_n}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      access(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_mem_lo", i), {16'd0, mem[vecs[i].lo_idx]}, {16'd0, vecs[i].exp_lo});
      check($sformatf("vec%0d_mem_hi", i), {16'd0, mem[vecs[i].lo_idx+1]}, {16'd0, vecs[i].exp_hi});
    end

    // Three reads back to back, each starting the cycle after the previous DONE.
    sum = 0;
    access(1'b0, 1'b1, 32'd1024, 32'd0, lat); sum += lat;
    check("b2b_rd0", read_data, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'd1032, 32'd0, lat); sum += lat;
    check("b2b_rd1", read_data, 32'h1234_5678);
    access(1'b0, 1'b1, 32'd1028, 32'd0, lat); sum += lat;
    check("b2b_rd2", read_data, 32'hA5A5_0F0F);
    check("b2b_total_cycles", 32'(sum), 32'(3 * LAT));

    // Address wrap: offset 2^19 bytes folds back onto word 0.
    access(1'b1, 1'b0, 32'd1024 + 32'h0008_0000, 32'h0BAD_F00D, lat);
    access(1'b0, 1'b1, 32'd1024, 32'd0, lat);
    check("wrap_read", read_data, 32'h0BAD_F00D);

    // Reset during HIGH of a write: low half lands, high half is untouched.
    access(1'b1, 1'b0, 32'd1060, 32'h1111_2222, lat);
    wr_en = 1'b1; address = 32'd1060; write_data = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; wr_en = 1'b0;
    #1;
    check("abort_we_n", {31'd0, we_n}, 32'd1);
    check("abort_read_data", read_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check("abort_mem_hi", {16'd0, mem[19]}, 32'h0000_1111);
    check("abort_mem_lo", {16'd0, mem[18]}, 32'h0000_F00D);
    ref_mem[9] = 32'h1111_F00D;
    ref_rd = 32'd0;
    access(1'b0, 1'b1, 32'd1060, 32'd0, lat);
    check("post_abort_latency", 32'(lat), 32'(LAT));
    check("post_abort_read", read_data, 32'h1111_F00D);

    // Randomized traffic against the word-level model.
    for (int i = 0; i < 40; i++) begin
      idx = int'($urandom_range(0, 31));
      a = 32'd1024 + 32'(idx) * 32'd4;
      d = $urandom;
      w = !ref_mem.exists(idx) || ($urandom_range(0, 1) == 1);
      r = !w || ($urandom_range(0, 3) == 0);
      access(w, r, a, d, lat);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("rand%0d_read_data", i), read_data, ref_rd);
    end

    // Single-wait build.
    access1(1'b1, 32'd1024, 32'h1357_9BDF, lat);
    check("w1_write_latency", 32'(lat), 32'(LAT1));
    check("w1_mem_lo", {16'd0, c_mem[0]}, 32'h0000_9BDF);
    check("w1_mem_hi", {16'd0, c_mem[1]}, 32'h0000_1357);
    access1(1'b0, 32'd1024, 32'd0, lat);
    check("w1_read_latency", 32'(lat), 32'(LAT1));
    check("w1_read_data", c_read_data, 32'h1357_9BDF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
